// File: rtl/bytewrite_ram_pkg.sv
// Shared constants and sizing helpers for the byte-write RAM port master.
package bytewrite_ram_pkg;

    localparam int DEF_NUM_COL    = 4;
    localparam int DEF_COL_WIDTH  = 8;
    localparam int DEF_ADDR_WIDTH = 10;
    localparam int DEF_RSP_DEPTH  = 4;

    // Word width built from lane count and lane width.
    function automatic int dataWidth(input int numCol, input int colWidth);
        return numCol * colWidth;
    endfunction

    // Width able to hold every occupancy value 0..depth inclusive.
    function automatic int countWidth(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/bytewrite_rsp_fifo.sv
// Response FIFO: synchronous, any depth >= 2, occupancy count exposed so the
// requester can do credit accounting. The head entry drives popData directly.
module bytewrite_rsp_fifo
    import bytewrite_ram_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = countWidth(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             popReady,
    output logic             popValid,
    output logic [WIDTH-1:0] popData,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic             doPush;
    logic             doPop;

    // Explicit compare-and-clear so non-power-of-two depths wrap correctly.
    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
    endfunction

    assign popValid = (count != '0);
    assign doPop    = popValid & popReady;
    assign doPush   = push;
    // Output reads as zero when empty so the idle value is deterministic.
    assign popData  = popValid ? mem[rdPtr] : '0;

    // Storage array: data only, never reset.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= pushData;
        end
    end

    // Pointers and occupancy; push and pop together leave count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= nextPtr(wrPtr);
            end
            if (doPop) begin
                rdPtr <= nextPtr(rdPtr);
            end
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Upstream credit accounting must never let occupancy exceed the depth.
    assert property (@(posedge clk) disable iff (!rst_n)
        (count <= FULL_CNT) && !(doPush && !doPop && (count == FULL_CNT)));

endmodule

// File: rtl/bytewrite_ram_port_master.sv
// Requester-side adapter for one port of the byte-write dual-port BRAM.
// Requests are issued straight to the RAM port; read data comes back one
// cycle later and is parked in a response FIFO. A request is only accepted
// when the FIFO has room for every read already in flight, so read data is
// never dropped when the consumer stalls.
module bytewrite_ram_port_master
    import bytewrite_ram_pkg::*;
#(
    parameter int NUM_COL    = DEF_NUM_COL,
    parameter int COL_WIDTH  = DEF_COL_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = dataWidth(NUM_COL, COL_WIDTH),
    parameter int RSP_DEPTH  = DEF_RSP_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_COL-1:0]    req_be,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  ram_en,
    output logic [NUM_COL-1:0]    ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    localparam int CNT_W = countWidth(RSP_DEPTH);
    localparam logic [CNT_W:0] DEPTH_LIM = (CNT_W + 1)'(RSP_DEPTH);

    if (RSP_DEPTH < 2 || RSP_DEPTH > 16) begin : gBadDepth
        $error("bytewrite_ram_port_master: RSP_DEPTH must be in 2..16");
    end

    logic             accept;
    logic             rdPend;
    logic [CNT_W-1:0] rspCount;
    logic [CNT_W:0]   inFlight;

    // Credit: FIFO entries already used plus the read whose data lands this
    // cycle. Both terms are registered, so req_ready never depends on the
    // consumer or on req_valid. Writes obey the same gate to keep order.
    assign inFlight  = {1'b0, rspCount} + {{CNT_W{1'b0}}, rdPend};
    assign req_ready = (inFlight < DEPTH_LIM);
    assign accept    = req_valid & req_ready;

    // The RAM port is driven straight from the accepted request; the strobes
    // are additionally held low while reset is asserted.
    assign ram_en   = accept & rst_n;
    assign ram_we   = (accept & rst_n & req_write) ? req_be : '0;
    assign ram_addr = req_addr;
    assign ram_din  = req_wdata;

    // rdPend marks the cycle in which the RAM presents data for last cycle's read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdPend <= 1'b0;
        end else begin
            rdPend <= accept & ~req_write;
        end
    end

    bytewrite_rsp_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (RSP_DEPTH),
        .CNT_W (CNT_W)
    ) rspFifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (rdPend),
        .pushData (ram_dout),
        .popReady (rsp_ready),
        .popValid (rsp_valid),
        .popData  (rsp_rdata),
        .count    (rspCount)
    );

endmodule

// File: tb/tb_bytewrite_ram_port_master.sv
// Directed bench for bytewrite_ram_port_master with a behavioural
// write-first byte-write RAM port attached to the RAM-side pins.
module tb_bytewrite_ram_port_master;

    localparam int NC = 4;
    localparam int CW = 8;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int RD = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [NC-1:0] req_be = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_rdata;
    logic          ram_en;
    logic [NC-1:0] ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    bytewrite_ram_port_master #(
        .NUM_COL    (NC),
        .COL_WIDTH  (CW),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .RSP_DEPTH  (RD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_be    (req_be),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    // Behavioural RAM port: byte-lane writes, write-first, 1-cycle registered read.
    logic [DW-1:0] ramMem [0:(1<<AW)-1];
    logic [DW-1:0] ramDout;
    assign ram_dout = ramDout;

    function automatic logic [DW-1:0] mergeLanes(input logic [DW-1:0] old,
                                                 input logic [DW-1:0] din,
                                                 input logic [NC-1:0] we);
        logic [DW-1:0] r;
        r = old;
        for (int i = 0; i < NC; i++) begin
            if (we[i]) r[i*CW +: CW] = din[i*CW +: CW];
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (ram_en) begin
            ramMem[ram_addr] <= mergeLanes(ramMem[ram_addr], ram_din, ram_we);
            ramDout          <= mergeLanes(ramMem[ram_addr], ram_din, ram_we);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request, wait (bounded) for acceptance, then drop req_valid.
    task automatic issue(input logic wr, input logic [AW-1:0] a,
                         input logic [NC-1:0] be, input logic [DW-1:0] d);
        int n;
        n = 0;
        req_valid = 1'b1; req_write = wr; req_addr = a; req_be = be; req_wdata = d;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        if (!req_ready) begin
            $display("FAIL issue_timeout addr=%h req_ready=%b required=1", a, req_ready);
            $fatal(1);
        end
        tick();
        req_valid = 1'b0;
    endtask

    // Wait (bounded) until a response is presented; leaves the bench on that cycle.
    task automatic waitRsp();
        int n;
        n = 0;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
        if (!rsp_valid) begin
            $display("FAIL rsp_timeout rsp_valid=%b required=1", rsp_valid);
            $fatal(1);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 1'b1; req_write = 1'b1; req_be = 4'hF; req_addr = 10'h3FF;
        req_wdata = 32'hDEAD_DEAD;
        tick();
        tick();
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b required=0", rsp_valid); end
        total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rsp_rdata got=%h required=0", rsp_rdata); end
        total++; if (ram_en !== 1'b0) begin bad++; $display("FAIL reset_ram_en got=%b required=0", ram_en); end
        total++; if (ram_we !== 4'h0) begin bad++; $display("FAIL reset_ram_we got=%h required=0", ram_we); end
        req_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL release_req_ready got=%b required=1", req_ready); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL release_rsp_valid got=%b required=0", rsp_valid); end
    endtask

    task automatic test_preload();
        for (int i = 0; i < 16; i++) begin
            issue(1'b1, AW'(i), 4'hF, 32'hC0DE_0000 + i);
        end
        tick();
        tick();
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL writes_no_rsp got=%b required=0", rsp_valid); end
    endtask

    task automatic test_write_read();
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 10'h010; req_be = 4'hF;
        req_wdata = 32'hA5A5_1234;
        #1;
        total++; if (ram_en !== 1'b1) begin bad++; $display("FAIL wr_ram_en got=%b required=1", ram_en); end
        total++; if (ram_we !== 4'hF) begin bad++; $display("FAIL wr_ram_we got=%h required=f", ram_we); end
        total++; if (ram_addr !== 10'h010) begin bad++; $display("FAIL wr_ram_addr got=%h required=010", ram_addr); end
        total++; if (ram_din !== 32'hA5A5_1234) begin bad++; $display("FAIL wr_ram_din got=%h required=a5a51234", ram_din); end
        tick();
        req_write = 1'b0; req_wdata = 32'h0;
        #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rd_req_ready got=%b required=1", req_ready); end
        total++; if (ram_we !== 4'h0) begin bad++; $display("FAIL rd_ram_we got=%h required=0", ram_we); end
        tick();
        req_valid = 1'b0;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rd_lat_t1 got=%b required=0", rsp_valid); end
        tick();
        total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL rd_lat_t2 got=%b required=1", rsp_valid); end
        total++; if (rsp_rdata !== 32'hA5A5_1234) begin bad++; $display("FAIL rd_data got=%h required=a5a51234", rsp_rdata); end
        tick();
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rd_one_beat got=%b required=0", rsp_valid); end
    endtask

    task automatic test_byte_mask();
        issue(1'b1, 10'h020, 4'hF, 32'hFFFF_FFFF);
        issue(1'b1, 10'h020, 4'b0101, 32'h0000_0000);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 10'h020; req_be = 4'h0;
        req_wdata = 32'h1234_5678;
        #1;
        total++; if (ram_en !== 1'b1) begin bad++; $display("FAIL be0_ram_en got=%b required=1", ram_en); end
        total++; if (ram_we !== 4'h0) begin bad++; $display("FAIL be0_ram_we got=%h required=0", ram_we); end
        tick();
        req_valid = 1'b0;
        tick();
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL be0_no_rsp got=%b required=0", rsp_valid); end
        issue(1'b0, 10'h020, 4'h0, 32'h0);
        waitRsp();
        total++; if (rsp_rdata !== 32'hFF00_FF00) begin bad++; $display("FAIL byte_mask got=%h required=ff00ff00", rsp_rdata); end
        tick();
    endtask

    task automatic test_backpressure();
        int acc;
        int got;
        logic ok;
        logic [DW-1:0] held;
        logic [DW-1:0] seen [6];
        acc = 0; got = 0;
        rsp_ready = 1'b0; req_write = 1'b0; req_be = '0;
        for (int c = 0; c < 8; c++) begin
            req_valid = (acc < 6); req_addr = AW'(acc);
            ok = req_valid & req_ready;
            tick();
            if (ok) acc++;
        end
        total++; if (acc !== 4) begin bad++; $display("FAIL bp_accepted got=%0d required=4", acc); end
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL bp_req_ready got=%b required=0", req_ready); end
        total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_rsp_valid got=%b required=1", rsp_valid); end
        held = rsp_rdata;
        tick();
        tick();
        total++; if (rsp_rdata !== 32'hC0DE_0000) begin bad++; $display("FAIL bp_head_stable got=%h required=c0de0000 (first seen %h)", rsp_rdata, held); end
        rsp_ready = 1'b1;
        for (int c = 0; c < 30 && !(acc == 6 && got == 6); c++) begin
            req_valid = (acc < 6); req_addr = AW'(acc);
            ok = req_valid & req_ready;
            if (rsp_valid && got < 6) begin
                seen[got] = rsp_rdata;
                got++;
            end
            tick();
            if (ok) acc++;
        end
        req_valid = 1'b0;
        total++; if (acc !== 6) begin bad++; $display("FAIL bp_total_accepted got=%0d required=6", acc); end
        total++; if (got !== 6) begin bad++; $display("FAIL bp_total_rsp got=%0d required=6", got); end
        for (int k = 0; k < got; k++) begin
            total++;
            if (seen[k] !== 32'hC0DE_0000 + k) begin
                bad++; $display("FAIL bp_order[%0d] got=%h required=%h", k, seen[k], 32'hC0DE_0000 + k);
            end
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int acc;
        int got;
        int drop;
        logic ok;
        logic [DW-1:0] seen [16];
        int cyc [16];
        acc = 0; got = 0; drop = 0;
        rsp_ready = 1'b1; req_write = 1'b0; req_be = '0;
        for (int c = 0; c < 24; c++) begin
            req_valid = (acc < 16); req_addr = AW'(acc);
            if (req_valid && !req_ready) drop++;
            ok = req_valid & req_ready;
            if (rsp_valid && got < 16) begin
                seen[got] = rsp_rdata;
                cyc[got] = c;
                got++;
            end
            tick();
            if (ok) acc++;
        end
        req_valid = 1'b0;
        total++; if (drop !== 0) begin bad++; $display("FAIL b2b_ready_drops got=%0d required=0", drop); end
        total++; if (got !== 16) begin bad++; $display("FAIL b2b_rsp_count got=%0d required=16", got); end
        for (int k = 0; k < got; k++) begin
            total++;
            if (seen[k] !== 32'hC0DE_0000 + k) begin
                bad++; $display("FAIL b2b_data[%0d] got=%h required=%h", k, seen[k], 32'hC0DE_0000 + k);
            end
            total++;
            if (cyc[k] !== k + 2) begin
                bad++; $display("FAIL b2b_cycle[%0d] got=%0d required=%0d", k, cyc[k], k + 2);
            end
        end
    endtask

    task automatic test_reset_midop();
        int stray;
        stray = 0;
        issue(1'b1, 10'h030, 4'hF, 32'h3030_ABCD);
        issue(1'b0, 10'h030, 4'h0, 32'h0);
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (rsp_valid) stray++;
            tick();
        end
        total++; if (stray !== 0) begin bad++; $display("FAIL midrst_stray_rsp got=%0d required=0", stray); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL midrst_req_ready got=%b required=1", req_ready); end
        total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL midrst_rdata got=%h required=0", rsp_rdata); end
        issue(1'b0, 10'h030, 4'h0, 32'h0);
        waitRsp();
        total++; if (rsp_rdata !== 32'h3030_ABCD) begin bad++; $display("FAIL midrst_ram_kept got=%h required=3030abcd", rsp_rdata); end
        tick();
    endtask

    task automatic test_write_first();
        issue(1'b1, 10'h040, 4'hF, 32'hDEAD_BEEF);
        tick();
        issue(1'b1, 10'h040, 4'hF, 32'h1111_2222);
        issue(1'b0, 10'h040, 4'h0, 32'h0);
        waitRsp();
        total++; if (rsp_rdata !== 32'h1111_2222) begin bad++; $display("FAIL write_first got=%h required=11112222", rsp_rdata); end
        tick();
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL write_first_one_beat got=%b required=0", rsp_valid); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_preload();
        test_write_read();
        test_byte_mask();
        test_backpressure();
        test_back_to_back();
        test_reset_midop();
        test_write_first();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
